mem_access_unit: RTL and testbench

- Memory-stage (M) load/store engine, directly downstream of the execute ALU.
- Consumes the ALU effective address (num1 + immediate) and the store data.
- Runs a two-phase request/data handshake on the data-SRAM bus, returns aligned and extended load data to writeback, and stalls the pipeline until the access completes.
- Raises address-error flags for misaligned accesses.

---
 rtl/mem_access_unit_pkg.sv | 29 ++
 rtl/mem_align.sv | 69 ++++++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store engine.
// Op codes, bus size codes and FSM states.
package mem_access_unit_pkg;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane replication, byte strobes, load extraction and
// misalignment detection for the memory stage.
module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] lane_wdata,
    output logic [3:0]  wstrb,
    output logic [1:0]  size,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        lane_wdata = wdata;
        wstrb      = 4'b0000;
        size       = SZ_WORD;
        misaligned = 1'b0;
        case (op)
            OP_LB, OP_LBU: size = SZ_BYTE;
            OP_LH, OP_LHU: begin
                size       = SZ_HALF;
                misaligned = addr_lo[0];
            end
            OP_SB: begin
                size       = SZ_BYTE;
                lane_wdata = {4{wdata[7:0]}};
                wstrb      = 4'b0001 << addr_lo;
            end
            OP_SH: begin
                size       = SZ_HALF;
                misaligned = addr_lo[0];
                lane_wdata = {2{wdata[15:0]}};
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                misaligned = |addr_lo;
                wstrb      = 4'b1111;
            end
            default: misaligned = |addr_lo;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            OP_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  rdata_ext = {24'd0, byte_sel};
            OP_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  rdata_ext = {16'd0, half_sel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: two-phase SRAM handshake,
// load extension, pipeline stall and address-error flags.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic              flush_M,
    input  logic              stall_M,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [ADDR_W-1:0] data_rdata,
    output logic [ADDR_W-1:0] rdata_out,
    output logic              mem_stall,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr
);

    state_t state, next_state;

    logic [2:0]        op_q;
    logic [1:0]        off_q;
    logic              cancel_q;
    logic [ADDR_W-1:0] lane_wdata;
    logic [ADDR_W-1:0] rdata_ext;
    logic [3:0]        wstrb;
    logic [1:0]        size;
    logic              misaligned;
    logic              start;
    logic              fault;
    logic              issue;
    logic              capture;
    logic              cancel_set;
    logic              cancel_clr;
    logic              req_d;

    mem_align u_align (
        .op         (mem_op),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .ld_op      (op_q),
        .ld_off     (off_q),
        .rdata      (data_rdata),
        .lane_wdata (lane_wdata),
        .wstrb      (wstrb),
        .size       (size),
        .misaligned (misaligned),
        .rdata_ext  (rdata_ext)
    );

    assign fault     = mem_en & misaligned;
    assign adel      = fault & ~is_store(mem_op);
    assign ades      = fault & is_store(mem_op);
    assign badvaddr  = fault ? addr : '0;
    assign start     = mem_en & ~misaligned & ~flush_M;
    assign mem_stall = start & (state != S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (start) next_state = S_ADDR;
            S_ADDR: begin
                if (data_addr_ok)  next_state = S_DATA;
                else if (flush_M)  next_state = S_IDLE;
            end
            S_DATA: begin
                // A cancelled access still drains, but skips DONE
                if (data_data_ok)
                    next_state = (cancel_q | flush_M) ? S_IDLE : S_DONE;
            end
            S_DONE: if (flush_M | ~stall_M) next_state = S_IDLE;
        endcase
    end

    always_comb begin
        issue      = (state == S_IDLE) & start;
        capture    = (state == S_DATA) & data_data_ok & ~data_wr
                   & ~(cancel_q | flush_M);
        cancel_set = ((state == S_ADDR) & data_addr_ok & flush_M)
                   | ((state == S_DATA) & flush_M & ~data_data_ok);
        cancel_clr = (state == S_DATA) & data_data_ok;
        req_d      = (next_state == S_ADDR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wdata <= '0;
            data_wstrb <= '0;
            rdata_out  <= '0;
            cancel_q   <= 1'b0;
            op_q       <= '0;
            off_q      <= '0;
        end else begin
            data_req <= req_d;
            if (issue) begin
                data_wr    <= is_store(mem_op);
                data_size  <= size;
                data_addr  <= addr;
                data_wdata <= lane_wdata;
                data_wstrb <= wstrb;
                op_q       <= mem_op;
                off_q      <= addr[1:0];
            end
            if (capture)         rdata_out <= rdata_ext;
            if (cancel_clr)      cancel_q  <= 1'b0;
            else if (cancel_set) cancel_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: latency, lanes,
// extension, address errors, flush and async reset.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic [2:0]  mem_op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        flush_M = 1'b0;
    logic        stall_M = 1'b0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic [31:0] rdata_out;
    logic        mem_stall, adel, ades;
    logic [31:0] badvaddr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [1:0]  cap_size;
    logic        cap_wr;
    logic [31:0] prev;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_op       (mem_op),
        .addr         (addr),
        .wdata        (wdata),
        .flush_M      (flush_M),
        .stall_M      (stall_M),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .rdata_out    (rdata_out),
        .mem_stall    (mem_stall),
        .adel         (adel),
        .ades         (ades),
        .badvaddr     (badvaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // cycle 0 request seen, ADDR for 1+dly cycles, one DATA cycle, DONE
    task automatic do_access(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int dly);
        mem_en = 1'b1; mem_op = op; addr = a; wdata = wd;
        #1;
        check("c0_req", {31'd0, data_req}, 32'd0);
        check("c0_stall", {31'd0, mem_stall}, 32'd1);
        next_cyc();
        for (int i = 0; i < dly; i++) begin
            #1;
            check("wait_req", {31'd0, data_req}, 32'd1);
            check("wait_addr", data_addr, a);
            check("wait_stall", {31'd0, mem_stall}, 32'd1);
            next_cyc();
        end
        data_addr_ok = 1'b1;
        #1;
        check("addr_req", {31'd0, data_req}, 32'd1);
        check("addr_addr", data_addr, a);
        cap_wdata = data_wdata; cap_wstrb = data_wstrb;
        cap_size = data_size; cap_wr = data_wr;
        next_cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
        #1;
        check("data_req", {31'd0, data_req}, 32'd0);
        check("data_stall", {31'd0, mem_stall}, 32'd1);
        next_cyc();
        data_data_ok = 1'b0;
        #1;
        check("done_stall", {31'd0, mem_stall}, 32'd0);
        next_cyc();
        mem_en = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        check("rst_req", {31'd0, data_req}, 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
        #10 rst = 1'b1;
        next_cyc();

        do_access(OP_LW, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw_data", rdata_out, 32'hDEAD_BEEF);
        check("lw_size", {30'd0, cap_size}, 32'd2);
        check("lw_wstrb", {28'd0, cap_wstrb}, 32'd0);
        check("lw_wr", {31'd0, cap_wr}, 32'd0);

        do_access(OP_LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        check("lb_data", rdata_out, 32'hFFFF_FF80);
        do_access(OP_LBU, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        check("lbu_data", rdata_out, 32'h0000_0080);
        do_access(OP_LH, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0);
        check("lh_data", rdata_out, 32'hFFFF_80FF);
        do_access(OP_LHU, 32'h0000_1000, 32'h0, 32'h80FF_9234, 0);
        check("lhu_data", rdata_out, 32'h0000_9234);

        prev = rdata_out;
        do_access(OP_SB, 32'h0000_2001, 32'h0000_00AB, 32'h1111_1111, 0);
        check("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        check("sb_wstrb", {28'd0, cap_wstrb}, 32'h2);
        check("sb_wr", {31'd0, cap_wr}, 32'd1);
        check("sb_size", {30'd0, cap_size}, 32'd0);
        check("sb_keep", rdata_out, prev);
        do_access(OP_SH, 32'h0000_2002, 32'h5566_1234, 32'h0, 0);
        check("sh_wdata", cap_wdata, 32'h1234_1234);
        check("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
        do_access(OP_SW, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 3);
        check("sw_wdata", cap_wdata, 32'hCAFE_F00D);
        check("sw_wstrb", {28'd0, cap_wstrb}, 32'hF);
        check("sw_size", {30'd0, cap_size}, 32'd2);

        mem_en = 1'b1; mem_op = OP_LW; addr = 32'h0000_1002;
        #1;
        check("mis_adel", {31'd0, adel}, 32'd1);
        check("mis_ades", {31'd0, ades}, 32'd0);
        check("mis_bad", badvaddr, 32'h0000_1002);
        check("mis_stall", {31'd0, mem_stall}, 32'd0);
        next_cyc();
        check("mis_req", {31'd0, data_req}, 32'd0);
        mem_op = OP_SH; addr = 32'h0000_2001;
        #1;
        check("mis_sh_ades", {31'd0, ades}, 32'd1);
        check("mis_sh_adel", {31'd0, adel}, 32'd0);
        next_cyc();
        check("mis_sh_req", {31'd0, data_req}, 32'd0);
        mem_en = 1'b0;
        #1;
        check("ok_bad", badvaddr, 32'd0);
        next_cyc();

        // flush while the read is in flight
        prev = rdata_out;
        mem_en = 1'b1; mem_op = OP_LW; addr = 32'h0000_3000;
        next_cyc();
        data_addr_ok = 1'b1;
        next_cyc();
        data_addr_ok = 1'b0; flush_M = 1'b1;
        #1;
        check("fl_stall", {31'd0, mem_stall}, 32'd0);
        next_cyc();
        flush_M = 1'b0; mem_en = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
        next_cyc();
        data_data_ok = 1'b0;
        #1;
        check("fl_keep", rdata_out, prev);
        check("fl_req", {31'd0, data_req}, 32'd0);
        do_access(OP_LW, 32'h0000_3004, 32'h0, 32'h0BAD_CAFE, 0);
        check("fl_next", rdata_out, 32'h0BAD_CAFE);

        // async reset while in DATA
        mem_en = 1'b1; mem_op = OP_SW; addr = 32'h0000_4000;
        wdata = 32'h1234_5678;
        next_cyc();
        data_addr_ok = 1'b1;
        next_cyc();
        data_addr_ok = 1'b0;
        #2 rst = 1'b0;
        mem_en = 1'b0;
        #1;
        check("ar_addr", data_addr, 32'd0);
        check("ar_wdata", data_wdata, 32'd0);
        check("ar_rdata", rdata_out, 32'd0);
        check("ar_wr", {31'd0, data_wr}, 32'd0);
        next_cyc();
        rst = 1'b1;
        next_cyc();
        do_access(OP_LW, 32'h0000_1000, 32'h0, 32'h7777_0001, 0);
        check("ar_next", rdata_out, 32'h7777_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
